// File: rtl/usb_hub_port_router.sv
// usb_hub_port_router
//
// Packet router between the hub's upstream transceiver byte path and
// NUM_PORTS downstream port byte paths.
//
// Downstream (host -> devices): each accepted host beat is registered once
// and presented to every port in the packet's active mask. Each port clears
// its own pending bit when it accepts, and a new beat is taken only when no
// port is still pending.
//
// Upstream (devices -> host): each port owns a FIFO of {last, data} entries.
// Bytes are written speculatively and only become readable once the packet's
// last byte lands (commit). A round-robin arbiter forwards whole committed
// packets, one at a time.
//
// Ports:
//   clock, reset        single clock, asynchronous active-low reset
//   port_enable         per-port enable mask
//   dn_in_*             host-to-device beat in (val/ready/last)
//   dn_out_*            per-port broadcast beat out, port i data at
//                       [i*DATA_WIDTH +: DATA_WIDTH]
//   up_in_*             per-port device bytes in (no backpressure)
//   up_out_*            forwarded upstream beat plus its source port
//   overflow_err        one-cycle pulse when a port drops a packet
//   pkt_pending         port holds at least one committed packet
module usb_hub_port_router #(
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [NUM_PORTS-1:0]               port_enable,
    input  logic [DATA_WIDTH-1:0]              dn_in_data,
    input  logic                               dn_in_val,
    input  logic                               dn_in_last,
    output logic                               dn_in_ready,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]    dn_out_data,
    output logic [NUM_PORTS-1:0]               dn_out_val,
    output logic [NUM_PORTS-1:0]               dn_out_last,
    input  logic [NUM_PORTS-1:0]               dn_out_ready,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]    up_in_data,
    input  logic [NUM_PORTS-1:0]               up_in_val,
    input  logic [NUM_PORTS-1:0]               up_in_last,
    output logic [DATA_WIDTH-1:0]              up_out_data,
    output logic                               up_out_val,
    output logic                               up_out_last,
    output logic [$clog2(NUM_PORTS)-1:0]       up_out_port,
    input  logic                               up_out_ready,
    output logic [NUM_PORTS-1:0]               overflow_err,
    output logic [NUM_PORTS-1:0]               pkt_pending
);

    localparam int PORT_W  = $clog2(NUM_PORTS);
    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int PTR_W   = AW + 1;
    localparam int ENTRY_W = DATA_WIDTH + 1;

    // ------------------------------------------------------------------
    // Downstream registered broadcast stage
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] dn_data_q;
    logic                  dn_last_q;
    logic [NUM_PORTS-1:0]  dn_pend;
    logic [NUM_PORTS-1:0]  dn_mask_q;
    logic [NUM_PORTS-1:0]  dn_mask_cur;
    logic [NUM_PORTS-1:0]  dn_remaining;
    logic                  dn_in_pkt;
    logic                  dn_accept;

    // The mask is taken from port_enable on the first beat of a packet and
    // held until the last beat, so mid-packet enable changes cannot split a
    // packet. Ready is forced low while reset is asserted.
    always_comb begin
        dn_remaining = dn_pend & ~dn_out_ready;
        dn_in_ready  = reset & ~|dn_remaining;
        dn_accept    = dn_in_val & dn_in_ready;
        dn_mask_cur  = dn_in_pkt ? dn_mask_q : port_enable;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dn_data_q <= '0;
            dn_last_q <= 1'b0;
            dn_pend   <= '0;
            dn_mask_q <= '0;
            dn_in_pkt <= 1'b0;
        end else if (dn_accept) begin
            dn_data_q <= dn_in_data;
            dn_last_q <= dn_in_last;
            dn_pend   <= dn_mask_cur;
            dn_mask_q <= dn_mask_cur;
            dn_in_pkt <= ~dn_in_last;
        end else begin
            dn_pend   <= dn_remaining;
        end
    end

    assign dn_out_val  = dn_pend;
    assign dn_out_last = dn_pend & {NUM_PORTS{dn_last_q}};
    assign dn_out_data = {NUM_PORTS{dn_data_q}};

    // ------------------------------------------------------------------
    // Upstream per-port FIFOs with packet commit
    // ------------------------------------------------------------------
    logic [ENTRY_W-1:0]   fifo_mem [NUM_PORTS][FIFO_DEPTH];
    logic [PTR_W-1:0]     wp [NUM_PORTS];
    logic [PTR_W-1:0]     cp [NUM_PORTS];
    logic [PTR_W-1:0]     rp [NUM_PORTS];
    logic [NUM_PORTS-1:0] up_in_pkt;
    logic [NUM_PORTS-1:0] up_en_q;
    logic [NUM_PORTS-1:0] up_drop;
    logic [NUM_PORTS-1:0] up_en_cur;
    logic [NUM_PORTS-1:0] up_active;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] wr_en;
    logic [NUM_PORTS-1:0] ovf_now;
    logic                 rd_fire;
    logic [PORT_W-1:0]    grant;

    // Full compares against rp before any same-cycle read, so a byte can be
    // refused even though a slot frees at the same edge.
    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            up_en_cur[i]   = up_in_pkt[i] ? up_en_q[i] : port_enable[i];
            up_active[i]   = up_in_val[i] & up_en_cur[i] & ~up_drop[i];
            fifo_full[i]   = (wp[i] - rp[i]) == PTR_W'(FIFO_DEPTH);
            wr_en[i]       = up_active[i] & ~fifo_full[i];
            ovf_now[i]     = up_active[i] & fifo_full[i];
            pkt_pending[i] = (cp[i] != rp[i]);
        end
    end

    // On overflow the speculative pointer rewinds to the last commit point,
    // and the rest of the packet (through its last byte) is discarded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                wp[i] <= '0;
                cp[i] <= '0;
                rp[i] <= '0;
            end
            up_in_pkt    <= '0;
            up_en_q      <= '0;
            up_drop      <= '0;
            overflow_err <= '0;
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                overflow_err[i] <= ovf_now[i];
                if (up_in_val[i]) begin
                    up_in_pkt[i] <= ~up_in_last[i];
                    up_en_q[i]   <= up_en_cur[i];
                    if (up_en_cur[i]) begin
                        up_drop[i] <= ~up_in_last[i] & (up_drop[i] | fifo_full[i]);
                    end
                end
                if (wr_en[i]) begin
                    wp[i] <= wp[i] + 1'b1;
                    if (up_in_last[i]) begin
                        cp[i] <= wp[i] + 1'b1;
                    end
                end else if (ovf_now[i]) begin
                    wp[i] <= cp[i];
                end
                if (rd_fire && (grant == PORT_W'(i))) begin
                    rp[i] <= rp[i] + 1'b1;
                end
            end
        end
    end

    // Storage array carries no reset; entries are only read once committed.
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_en[i]) begin
                fifo_mem[i][wp[i][AW-1:0]] <=
                    {up_in_last[i], up_in_data[i*DATA_WIDTH +: DATA_WIDTH]};
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin packet arbiter
    // ------------------------------------------------------------------
    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

    arb_state_t         state;
    arb_state_t         state_next;
    logic [PORT_W-1:0]  grant_next;
    logic [PORT_W-1:0]  last_grant;
    logic [ENTRY_W-1:0] head;
    logic               pick_found;
    int                 pick_idx;

    // Search starts just after last_grant so every port gets a turn. The
    // entry under rp[grant] is read straight from the array, so the head
    // byte is visible in the same cycle the grant takes effect.
    always_comb begin
        state_next  = state;
        grant_next  = grant;
        pick_found  = 1'b0;
        pick_idx    = 0;
        up_out_val  = 1'b0;
        up_out_data = '0;
        up_out_last = 1'b0;
        rd_fire     = 1'b0;
        head        = fifo_mem[grant][rp[grant][AW-1:0]];
        case (state)
            ARB_IDLE: begin
                for (int k = 1; k <= NUM_PORTS; k++) begin
                    pick_idx = (int'(last_grant) + k) % NUM_PORTS;
                    if (!pick_found && pkt_pending[pick_idx]) begin
                        pick_found = 1'b1;
                        grant_next = PORT_W'(pick_idx);
                    end
                end
                if (pick_found) begin
                    state_next = ARB_XFER;
                end
            end
            ARB_XFER: begin
                up_out_val  = 1'b1;
                up_out_data = head[DATA_WIDTH-1:0];
                up_out_last = head[DATA_WIDTH];
                rd_fire     = up_out_ready;
                if (up_out_ready && head[DATA_WIDTH]) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ARB_IDLE;
            grant      <= '0;
            last_grant <= PORT_W'(NUM_PORTS - 1);
        end else begin
            state <= state_next;
            grant <= grant_next;
            if (rd_fire && up_out_last) begin
                last_grant <= grant;
            end
        end
    end

    assign up_out_port = grant;

endmodule

// File: doc/usb_hub_port_router.md
Name: usb_hub_port_router

Overview:
- Parametrised packet router between the upstream transceiver byte path and N downstream port byte paths of the hub.
- Downstream direction: broadcasts each host packet to every enabled port through a registered stage with per-port acceptance tracking.
- Upstream direction: buffers device packets in per-port FIFOs with packet-commit semantics, then forwards whole packets one at a time under round-robin arbitration.
- Replaces the fixed two-device FIFO/mux wiring with a scalable, flow-controlled block.

Parameters:
NUM_PORTS, 4, number of downstream ports (2..8)
FIFO_DEPTH, 16, entries per upstream port FIFO; power of 2, >=4
DATA_WIDTH, 8, byte lane width

Ports:
clock  input  1  single clock for all logic
reset  input  1  asynchronous, active-low reset
port_enable  input  NUM_PORTS  per-port enable mask
dn_in_data  input  DATA_WIDTH  host-to-device byte
dn_in_val  input  1  dn_in_data valid
dn_in_last  input  1  final byte of host packet
dn_in_ready  output  1  router accepts dn_in beat
dn_out_data  output  NUM_PORTS*DATA_WIDTH  per-port broadcast byte, port i at [i*DATA_WIDTH +: DATA_WIDTH]
dn_out_val  output  NUM_PORTS  per-port valid
dn_out_last  output  NUM_PORTS  per-port last
dn_out_ready  input  NUM_PORTS  per-port downstream ready
up_in_data  input  NUM_PORTS*DATA_WIDTH  device-to-host bytes
up_in_val  input  NUM_PORTS  per-port byte valid (no backpressure)
up_in_last  input  NUM_PORTS  per-port last byte
up_out_data  output  DATA_WIDTH  forwarded byte
up_out_val  output  1  forwarded byte valid
up_out_last  output  1  last byte of forwarded packet
up_out_port  output  clog2(NUM_PORTS)  source port of current packet
up_out_ready  input  1  upstream consumer ready
overflow_err  output  NUM_PORTS  one-cycle pulse: packet dropped on overflow
pkt_pending  output  NUM_PORTS  port holds >=1 committed packet

Behaviour:
- Reset (reset=0, async): all outputs 0; FIFO pointers 0; arbiter in IDLE; last_grant=NUM_PORTS-1, so port 0 has first priority.
- Downstream registered stage:
  - Holds one beat plus pend[NUM_PORTS].
  - dn_out_val[i]=pend[i]; pend[i] clears on dn_out_ready[i].
  - dn_in_ready = ~|pend, or all remaining pend bits clear this cycle.
  - Accepted beat loads on the next edge; pend = active mask. Latency is 1 cycle.
- Active mask:
  - Sampled from port_enable on the first beat of a packet and held until the last beat is accepted.
  - Mid-packet enable changes are ignored.
  - If the mask is all zero, beats are accepted and discarded; dn_out_val stays 0.
- Upstream write, per port:
  - Entry = {last, data}; speculative write pointer wp, committed pointer cp.
  - On up_in_val with port enabled (sampled at first byte): write at wp, wp++.
  - On last: cp = wp+1.
  - Write when full (wp-rp == FIFO_DEPTH): set drop, rewind wp=cp, pulse overflow_err[i], discard bytes through up_in_last.
  - A packet longer than FIFO_DEPTH is always dropped.
  - Bytes on a disabled port are ignored.
- pkt_pending[i] = (cp != rp).
- Arbiter FSM, IDLE -> XFER -> IDLE:
  - IDLE: if any pkt_pending, grant the first pending port after last_grant, cyclically. Go to XFER and drive up_out_port from the next cycle.
  - XFER: up_out_val=1; up_out_data/last = entry at rp[grant], read combinationally from the register array.
  - On up_out_val & up_out_ready: rp++.
  - If the accepted beat has last=1: last_grant=grant, return to IDLE.
  - Minimum one idle cycle between packets.
- Grant is locked for the whole packet. Disabling the granted port mid-packet does not abort the transfer.
- Simultaneous write-commit and read on the same FIFO is legal. Full is computed from rp before the read.
- Pointers are clog2(FIFO_DEPTH)+1 bits and wrap naturally.
- Reset mid-packet: all state cleared; partial packets are lost; no overflow_err pulse.

Test Plan:
- Ports 0,2 enabled, 3-byte host packet A1,A2,A3; port 2 ready held low for 2 cycles -> ports 0,2 see A1..A3 with last on A3; dn_in_ready low while port 2 pending; ports 1,3 dn_out_val=0.
- Ports 1 and 3 commit 2-byte packets in the same cycle after reset -> port 1 is forwarded first (up_out_port=1), then port 3; one idle cycle between them; up_out_last on the 2nd byte of each.
- FIFO_DEPTH=16, port 0 sends 20 bytes -> overflow_err[0] pulses once; nothing forwarded; a following 4-byte packet is forwarded intact.
- Port 2 sends 5 bytes, reset asserted after byte 3 -> all outputs 0 immediately; pkt_pending=0 after release.
- Port 0 forwarding with up_out_ready toggling 1,0,1,0 while port 0 commits a new packet -> no data loss, bytes in order; second packet forwarded after the first.
- port_enable drops for the granted port mid-transfer -> current packet completes; subsequent bytes on that port are ignored.
